mem_stage_ooo: RTL and testbench

Parametrised successor to the current MEM pipeline stage. It sits between EX and WB on the sram-like data interface. It supports up to MAX_OUTSTANDING in-order data requests in flight and a DATA_W-wide datapath with generalised load extraction. It also drops stale data_ok responses after an exception flush. A one-entry response buffer decouples data_ok from ws_allowin.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_ooo_load_extract.sv | 48 ++++
 rtl/mem_stage_ooo.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_ooo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: load op encodings, default exception width,
// and the byte-offset width helper used for load extraction.
// No logic; no latency or backpressure of its own.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5,
        LD_WU   = 3'd6,
        LD_D    = 3'd7
    } ld_op_e;

    localparam int EXC_W_DEF = 7;

    // Number of address bits selecting a byte inside one DATA_W word.
    function automatic int off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_stage_ooo_load_extract.sv
// Load extraction: picks byte/half/word/double at the byte offset and extends it.
// Latency: purely combinational.
// Backpressure: none, it has no handshake.
module load_extract
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = off_width(DATA_W)
) (
    input  logic [DATA_W-1:0] i_raw,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [2:0]        i_ld_op,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_byte_s;
    logic [DATA_W-1:0] w_byte_u;
    logic [DATA_W-1:0] w_half_s;
    logic [DATA_W-1:0] w_half_u;
    logic [DATA_W-1:0] w_word_s;
    logic [DATA_W-1:0] w_word_u;

    // Bring the addressed item down to bit 0, then extend from there.
    assign w_shifted = i_raw >> {i_offset, 3'b000};
    assign w_byte_s  = DATA_W'($signed(w_shifted[7:0]));
    assign w_byte_u  = DATA_W'(w_shifted[7:0]);
    assign w_half_s  = DATA_W'($signed(w_shifted[15:0]));
    assign w_half_u  = DATA_W'(w_shifted[15:0]);
    assign w_word_s  = DATA_W'($signed(w_shifted[31:0]));
    assign w_word_u  = DATA_W'(w_shifted[31:0]);

    // Select the extension; on a 32-bit datapath WU and D degrade to W.
    always_comb begin
        o_data = i_raw;
        case (ld_op_e'(i_ld_op))
            LD_B:    o_data = w_byte_s;
            LD_BU:   o_data = w_byte_u;
            LD_H:    o_data = w_half_s;
            LD_HU:   o_data = w_half_u;
            LD_W:    o_data = w_word_s;
            LD_WU:   o_data = (DATA_W == 64) ? w_word_u  : w_word_s;
            LD_D:    o_data = (DATA_W == 64) ? w_shifted : w_word_s;
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_ooo.sv
// MEM pipeline stage with up to MAX_OUTSTANDING in-order data requests, stale-response cancel after flush, and a one-entry response buffer; MS_FWD_EN enables ms_fwd_ready.
// Latency: one cycle EX->WB for non-loads; loads complete in the cycle their data_ok arrives (or from the buffer).
// Backpressure: ms_allowin drops while a load waits for data or WB stalls; ms_req_block throttles EX request issue.
module mem_stage_ooo
    import mem_stage_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int EXC_W           = EXC_W_DEF,
    parameter int CNT_W           = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [31:0]       es_pc,
    input  logic              es_res_from_mem,
    input  logic              es_rf_we,
    input  logic [4:0]        es_rf_waddr,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic [2:0]        es_ld_op,
    input  logic              es_wait_data,
    input  logic [EXC_W-1:0]  es_except,
    input  logic              data_req_fire,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              ws_allowin,
    input  logic              except_flush,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic              ms_rf_we,
    output logic [4:0]        ms_rf_waddr,
    output logic [DATA_W-1:0] ms_rf_wdata,
    output logic [EXC_W-1:0]  ms_except,
    output logic [DATA_W-1:0] ms_vaddr,
    output logic              ms_req_block,
    output logic              ms_fwd_ready
);

    localparam int OFF_W = off_width(DATA_W);

    logic              r_ms_valid;
    logic [31:0]       r_pc;
    logic              r_res_from_mem;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_alu_result;
    logic [2:0]        r_ld_op;
    logic              r_wait_data;
    logic [EXC_W-1:0]  r_except;
    logic              r_buf_valid;
    logic [DATA_W-1:0] r_buf_data;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [CNT_W-1:0]  r_cancel_cnt;

    logic              w_live_ok;
    logic              w_wait;
    logic              w_ready_go;
    logic              w_capture;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_load_data;

    // A response belongs to the live pipeline only once all cancelled ones have drained.
    assign w_live_ok  = data_sram_data_ok & (r_cancel_cnt == '0);
    assign w_wait     = r_ms_valid & r_wait_data & ~r_buf_valid;
    assign w_ready_go = ~w_wait | w_live_ok;
    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;
    // Park data only for the waiting instruction, so a later response cannot overwrite it.
    assign w_capture  = w_live_ok & w_wait & ~ws_allowin;
    assign w_raw      = r_buf_valid ? r_buf_data : data_sram_rdata;

    load_extract #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_load_extract (
        .i_raw    (w_raw),
        .i_offset (r_alu_result[OFF_W-1:0]),
        .i_ld_op  (r_ld_op),
        .o_data   (w_load_data)
    );

    assign ms_pc        = r_pc;
    assign ms_rf_we     = r_ms_valid & r_rf_we;
    assign ms_rf_waddr  = r_rf_waddr;
    assign ms_rf_wdata  = r_res_from_mem ? w_load_data : r_alu_result;
    assign ms_except    = r_except;
    assign ms_vaddr     = r_alu_result;
    assign ms_req_block = (r_out_cnt >= CNT_W'(MAX_OUTSTANDING)) | (r_cancel_cnt != '0);

`ifdef MS_FWD_EN
    assign ms_fwd_ready = r_ms_valid & (~r_res_from_mem | r_buf_valid | w_live_ok);
`else
    assign ms_fwd_ready = 1'b0;
`endif

    // Stage valid and payload capture; a flush overrides a same-cycle accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid     <= 1'b0;
            r_pc           <= '0;
            r_res_from_mem <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_alu_result   <= '0;
            r_ld_op        <= '0;
            r_wait_data    <= 1'b0;
            r_except       <= '0;
        end else begin
            if (except_flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                r_pc           <= es_pc;
                r_res_from_mem <= es_res_from_mem;
                r_rf_we        <= es_rf_we;
                r_rf_waddr     <= es_rf_waddr;
                r_alu_result   <= es_alu_result;
                r_ld_op        <= es_ld_op;
                r_wait_data    <= es_wait_data;
                r_except       <= es_except;
            end
        end
    end

    // One-entry response buffer: filled when WB stalls, emptied when the instruction leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (except_flush) begin
            r_buf_valid <= 1'b0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Outstanding and cancel counters; every data_ok (kept or dropped) retires one request,
    // so on a flush only the requests still unreturned after this cycle are cancelled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt    <= '0;
            r_cancel_cnt <= '0;
        end else begin
            case ({data_req_fire, data_sram_data_ok})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (except_flush) begin
                r_cancel_cnt <= r_out_cnt - CNT_W'(data_sram_data_ok);
            end else if ((r_cancel_cnt != '0) && data_sram_data_ok) begin
                r_cancel_cnt <= r_cancel_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ooo.sv
// Directed bench for mem_stage_ooo: 32-bit instance for the control paths, 64-bit instance for wide loads.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Summary line reports failed and total comparisons.
module tb_mem_stage_ooo;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // 32-bit instance signals
    logic        es_to_ms_valid, es_res_from_mem, es_rf_we, es_wait_data;
    logic [31:0] es_pc, es_alu_result, data_sram_rdata;
    logic [4:0]  es_rf_waddr;
    logic [2:0]  es_ld_op;
    logic [6:0]  es_except;
    logic        data_req_fire, data_sram_data_ok, ws_allowin, except_flush;
    logic        ms_allowin, ms_to_ws_valid, ms_rf_we, ms_req_block, ms_fwd_ready;
    logic [31:0] ms_pc, ms_rf_wdata, ms_vaddr;
    logic [4:0]  ms_rf_waddr;
    logic [6:0]  ms_except;

    // 64-bit instance signals
    logic        b_valid, b_res_from_mem, b_rf_we, b_wait_data;
    logic [31:0] b_pc;
    logic [63:0] b_alu_result, b_rdata;
    logic [4:0]  b_rf_waddr;
    logic [2:0]  b_ld_op;
    logic [6:0]  b_except;
    logic        b_fire, b_data_ok, b_ws_allowin, b_flush;
    logic        b_allowin, b_to_ws_valid, b_ms_rf_we, b_req_block, b_fwd_ready;
    logic [31:0] b_ms_pc;
    logic [63:0] b_wdata, b_vaddr;
    logic [4:0]  b_ms_waddr;
    logic [6:0]  b_ms_except;

    always #5 clk = ~clk;

    mem_stage_ooo #(.DATA_W(32), .MAX_OUTSTANDING(2), .EXC_W(7), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_res_from_mem(es_res_from_mem), .es_rf_we(es_rf_we),
        .es_rf_waddr(es_rf_waddr), .es_alu_result(es_alu_result), .es_ld_op(es_ld_op),
        .es_wait_data(es_wait_data), .es_except(es_except),
        .data_req_fire(data_req_fire), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .except_flush(except_flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .ms_except(ms_except),
        .ms_vaddr(ms_vaddr), .ms_req_block(ms_req_block), .ms_fwd_ready(ms_fwd_ready)
    );

    mem_stage_ooo #(.DATA_W(64), .MAX_OUTSTANDING(2), .EXC_W(7), .CNT_W(3)) dut64 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(b_valid), .ms_allowin(b_allowin),
        .es_pc(b_pc), .es_res_from_mem(b_res_from_mem), .es_rf_we(b_rf_we),
        .es_rf_waddr(b_rf_waddr), .es_alu_result(b_alu_result), .es_ld_op(b_ld_op),
        .es_wait_data(b_wait_data), .es_except(b_except),
        .data_req_fire(b_fire), .data_sram_data_ok(b_data_ok),
        .data_sram_rdata(b_rdata), .ws_allowin(b_ws_allowin), .except_flush(b_flush),
        .ms_to_ws_valid(b_to_ws_valid), .ms_pc(b_ms_pc), .ms_rf_we(b_ms_rf_we),
        .ms_rf_waddr(b_ms_waddr), .ms_rf_wdata(b_wdata), .ms_except(b_ms_except),
        .ms_vaddr(b_vaddr), .ms_req_block(b_req_block), .ms_fwd_ready(b_fwd_ready)
    );

    task automatic idle();
        es_to_ms_valid = 0; es_res_from_mem = 0; es_rf_we = 0; es_wait_data = 0;
        es_pc = 0; es_alu_result = 0; es_rf_waddr = 0; es_ld_op = 0; es_except = 0;
        data_req_fire = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        ws_allowin = 1; except_flush = 0;
        b_valid = 0; b_res_from_mem = 0; b_rf_we = 0; b_wait_data = 0; b_pc = 0;
        b_alu_result = 0; b_rdata = 0; b_rf_waddr = 0; b_ld_op = 0; b_except = 0;
        b_fire = 0; b_data_ok = 0; b_ws_allowin = 1; b_flush = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a load in EX that issues its request this cycle.
    task automatic issue_load(input logic [2:0] op, input logic [31:0] addr);
        idle();
        es_to_ms_valid = 1; es_res_from_mem = 1; es_rf_we = 1; es_wait_data = 1;
        es_ld_op = op; es_alu_result = addr; es_rf_waddr = 5'd5; es_pc = 32'h100;
        es_except = 7'h55; data_req_fire = 1;
    endtask

    task automatic test_reset();
        idle();
        #2;
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b want 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_rf_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", ms_rf_wdata); end
        checks++; if (ms_req_block !== 1'b0 || ms_fwd_ready !== 1'b0 || ms_rf_we !== 1'b0) begin errors++; $display("FAIL rst_misc: got blk=%b fwd=%b we=%b want 0", ms_req_block, ms_fwd_ready, ms_rf_we); end
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_load_extract();
        // LD_B at offset 3, data one cycle after accept
        cyc(); issue_load(3'd1, 32'h1003);
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h8000_0000;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h want ffffff80", ms_rf_wdata); end
        checks++; if (ms_pc !== 32'h100 || ms_rf_waddr !== 5'd5 || ms_except !== 7'h55 || ms_vaddr !== 32'h1003 || ms_rf_we !== 1'b1) begin errors++; $display("FAIL lb_payload: got pc=%h wa=%0d ex=%h va=%h we=%b", ms_pc, ms_rf_waddr, ms_except, ms_vaddr, ms_rf_we); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.r_out_cnt !== 3'd0) begin errors++; $display("FAIL lb_retire: got valid=%b out=%0d want 0 0", ms_to_ws_valid, dut.r_out_cnt); end
        // LD_BU with one empty wait cycle first
        cyc(); issue_load(3'd2, 32'h1003);
        cyc(); idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL lbu_wait: got valid=%b allowin=%b want 0 0", ms_to_ws_valid, ms_allowin); end
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h8000_0000;
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'h0000_0080 || ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL lbu_wdata: got %h v=%b want 00000080 v=1", ms_rf_wdata, ms_to_ws_valid); end
        // LD_H / LD_HU at offset 2
        cyc(); issue_load(3'd3, 32'h2002);
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h8001_0000;
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_wdata: got %h want ffff8001", ms_rf_wdata); end
        cyc(); issue_load(3'd4, 32'h2002);
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h8001_0000;
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_wdata: got %h want 00008001", ms_rf_wdata); end
        // LD_D on a 32-bit datapath behaves as W
        cyc(); issue_load(3'd7, 32'h2000);
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h89AB_CDEF;
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'h89AB_CDEF) begin errors++; $display("FAIL ld32_wdata: got %h want 89abcdef", ms_rf_wdata); end
        cyc(); idle();
    endtask

    task automatic test_back_to_back();
        cyc(); idle(); es_to_ms_valid = 1; es_rf_we = 1; es_alu_result = 32'hDEAD_BEEF;
        cyc(); idle(); es_to_ms_valid = 1; es_rf_we = 1; es_alu_result = 32'h0000_0002;
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'hDEAD_BEEF || ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h v=%b a=%b want deadbeef 1 1", ms_rf_wdata, ms_to_ws_valid, ms_allowin); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (ms_rf_wdata !== 32'h0000_0002 || ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h v=%b want 00000002 1", ms_rf_wdata, ms_to_ws_valid); end
        cyc(); idle();
    endtask

    task automatic test_buffer();
        cyc(); issue_load(3'd5, 32'h3000);
        cyc(); idle(); ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin errors++; $display("FAIL buf_stall: got v=%b a=%b want 1 0", ms_to_ws_valid, ms_allowin); end
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); ws_allowin = 0; data_sram_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            checks++; if (dut.r_buf_valid !== 1'b1 || ms_rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL buf_hold: got bv=%b wdata=%h want 1 12345678", dut.r_buf_valid, ms_rf_wdata); end
        end
        cyc(); idle(); data_sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL buf_deliver: got v=%b wdata=%h want 1 12345678", ms_to_ws_valid, ms_rf_wdata); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.r_buf_valid !== 1'b0) begin errors++; $display("FAIL buf_clear: got v=%b bv=%b want 0 0", ms_to_ws_valid, dut.r_buf_valid); end
    endtask

    task automatic test_flush_cancel();
        cyc(); issue_load(3'd5, 32'h0);
        cyc(); idle(); es_to_ms_valid = 1; es_res_from_mem = 1; es_wait_data = 1; data_req_fire = 1;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b want 0", ms_allowin); end
        cyc(); idle(); except_flush = 1;
        @(negedge clk);
        checks++; if (ms_req_block !== 1'b1) begin errors++; $display("FAIL fl_block_full: got %b want 1", ms_req_block); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (dut.r_cancel_cnt !== 3'd2 || ms_req_block !== 1'b1 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_cancel2: got c=%0d blk=%b v=%b want 2 1 0", dut.r_cancel_cnt, ms_req_block, ms_to_ws_valid); end
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_0000;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_drop1: got v=%b want 0", ms_to_ws_valid); end
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_0001;
        @(negedge clk);
        checks++; if (dut.r_cancel_cnt !== 3'd1 || dut.r_buf_valid !== 1'b0) begin errors++; $display("FAIL fl_drop2: got c=%0d bv=%b want 1 0", dut.r_cancel_cnt, dut.r_buf_valid); end
        cyc(); idle();
        @(negedge clk);
        checks++; if (dut.r_cancel_cnt !== 3'd0 || dut.r_out_cnt !== 3'd0 || ms_req_block !== 1'b0) begin errors++; $display("FAIL fl_drained: got c=%0d o=%0d blk=%b want 0 0 0", dut.r_cancel_cnt, dut.r_out_cnt, ms_req_block); end
        cyc(); issue_load(3'd2, 32'h2000);
        cyc(); idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h0000_00AB;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_rf_wdata !== 32'h0000_00AB) begin errors++; $display("FAIL fl_third: got v=%b wdata=%h want 1 000000ab", ms_to_ws_valid, ms_rf_wdata); end
        cyc(); idle();
    endtask

    task automatic test_flush_with_ok();
        cyc(); issue_load(3'd5, 32'h0);
        cyc(); idle(); data_req_fire = 1;
        cyc(); idle(); except_flush = 1; data_sram_data_ok = 1;
        cyc(); idle();
        @(negedge clk);
        checks++; if (dut.r_cancel_cnt !== 3'd1 || dut.r_out_cnt !== 3'd1) begin errors++; $display("FAIL flok_cancel: got c=%0d o=%0d want 1 1", dut.r_cancel_cnt, dut.r_out_cnt); end
        cyc(); idle(); data_sram_data_ok = 1;
        cyc(); idle();
        @(negedge clk);
        checks++; if (dut.r_cancel_cnt !== 3'd0 || dut.r_out_cnt !== 3'd0) begin errors++; $display("FAIL flok_drain: got c=%0d o=%0d want 0 0", dut.r_cancel_cnt, dut.r_out_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        cyc(); issue_load(3'd5, 32'h0);
        cyc(); idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.r_out_cnt !== 3'd1) begin errors++; $display("FAIL rmw_pre: got v=%b o=%0d want 0 1", ms_to_ws_valid, dut.r_out_cnt); end
        #2 resetn = 0;
        #1;
        checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || dut.r_out_cnt !== 3'd0 || dut.r_ms_valid !== 1'b0) begin errors++; $display("FAIL rmw_clear: got a=%b v=%b o=%0d mv=%b want 1 0 0 0", ms_allowin, ms_to_ws_valid, dut.r_out_cnt, dut.r_ms_valid); end
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_wide64();
        cyc(); idle();
        b_valid = 1; b_res_from_mem = 1; b_rf_we = 1; b_wait_data = 1; b_fire = 1;
        b_ld_op = 3'd6; b_alu_result = 64'h4;
        cyc(); idle(); b_data_ok = 1; b_rdata = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        checks++; if (b_to_ws_valid !== 1'b1 || b_wdata !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL w64_lwu: got v=%b wdata=%h want 1 00000000ffffffff", b_to_ws_valid, b_wdata); end
        cyc(); idle();
        b_valid = 1; b_res_from_mem = 1; b_rf_we = 1; b_wait_data = 1; b_fire = 1;
        b_ld_op = 3'd5; b_alu_result = 64'h4;
        cyc(); idle(); b_data_ok = 1; b_rdata = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        checks++; if (b_wdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL w64_lw: got %h want ffffffffffffffff", b_wdata); end
        cyc(); idle();
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_back_to_back();
        test_buffer();
        test_flush_cancel();
        test_flush_with_ok();
        test_reset_mid_wait();
        test_wide64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
